gpr_csr_regfile: RTL and testbench



---
 rtl/gpr_csr_regfile_if.sv | 25 ++
 rtl/gpr_csr_regfile.sv | 154 +++++++++++++++
 tb/tb_gpr_csr_regfile.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpr_csr_regfile_if.sv
// rtl/gpr_csr_regfile_if.sv - writeback handshake bundle between retire stage and regfile
interface gpr_csr_regfile_if;
  logic        wb_valid;
  logic        wb_ready;
  logic        gpr_we;
  logic [3:0]  gpr_waddr;
  logic [31:0] gpr_wdata;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        irq;
  logic [7:0]  irq_no;

  modport master (
    output wb_valid, gpr_we, gpr_waddr, gpr_wdata,
    output csr_we, csr_waddr, csr_wdata, irq, irq_no,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, gpr_we, gpr_waddr, gpr_wdata,
    input  csr_we, csr_waddr, csr_wdata, irq, irq_no,
    output wb_ready
  );
endinterface

// File: rtl/gpr_csr_regfile.sv
// rtl/gpr_csr_regfile.sv - RV32E GPRs, machine CSRs and RAW scoreboard at the writeback sink
module gpr_csr_regfile (
  input  logic                    clk,
  input  logic                    reset,
  gpr_csr_regfile_if.slave        wb,
  input  logic [3:0]              rs1_addr,
  input  logic [3:0]              rs2_addr,
  output logic [31:0]             rs1_data,
  output logic [31:0]             rs2_data,
  input  logic [11:0]             csr_raddr,
  output logic [31:0]             csr_rdata,
  output logic [31:0]             mtvec_o,
  output logic [31:0]             mepc_o,
  input  logic                    issue_valid,
  input  logic [3:0]              issue_rd,
  output logic                    hazard,
  output logic                    issue_full
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [31:0] MSTATUS_RST = 32'h0000_1800;

  logic        wb_ready_q, wb_ready_d;
  logic [31:0] gpr_q [16];
  logic [31:0] gpr_d [16];
  logic [1:0]  cnt_q [16];
  logic [1:0]  cnt_d [16];
  logic [31:0] mstatus_q, mstatus_d;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;

  logic wb_fire;
  logic gpr_wr;
  logic trap;
  logic csr_wr;

  assign wb.wb_ready = wb_ready_q;
  assign wb_fire     = wb.wb_valid && wb_ready_q;
  assign gpr_wr      = wb_fire && wb.gpr_we && (wb.gpr_waddr != 4'd0);
  assign trap        = wb_fire && wb.irq;
  assign csr_wr      = wb_fire && wb.csr_we && !wb.irq;

  assign mtvec_o = mtvec_q;
  assign mepc_o  = mepc_q;

  always_comb begin
    wb_ready_d = 1'b1;
    gpr_d      = gpr_q;
    if (gpr_wr) begin
      gpr_d[wb.gpr_waddr] = wb.gpr_wdata;
    end
    gpr_d[0] = '0;
  end

  // Trap entry takes priority and suppresses the beat's own CSR write.
  always_comb begin
    mstatus_d = mstatus_q;
    mtvec_d   = mtvec_q;
    mepc_d    = mepc_q;
    mcause_d  = mcause_q;
    if (trap) begin
      mepc_d             = wb.csr_wdata;
      mcause_d           = {24'h0, wb.irq_no};
      mstatus_d[7]       = mstatus_q[3];
      mstatus_d[3]       = 1'b0;
      mstatus_d[12:11]   = 2'b11;
    end else if (csr_wr) begin
      case (wb.csr_waddr)
        CSR_MSTATUS: mstatus_d = wb.csr_wdata;
        CSR_MTVEC:   mtvec_d   = wb.csr_wdata;
        CSR_MEPC:    mepc_d    = wb.csr_wdata;
        CSR_MCAUSE:  mcause_d  = wb.csr_wdata;
        default:     ;
      endcase
    end
  end

  // An issue and a retirement to the same register cancel, even at saturation.
  always_comb begin
    logic iss;
    logic ret;
    cnt_d[0] = 2'd0;
    for (int i = 1; i < 16; i++) begin
      iss      = issue_valid && (issue_rd == 4'(i));
      ret      = gpr_wr && (wb.gpr_waddr == 4'(i));
      cnt_d[i] = cnt_q[i];
      if (iss && ret) begin
        cnt_d[i] = cnt_q[i];
      end else if (iss && (cnt_q[i] != 2'd3)) begin
        cnt_d[i] = cnt_q[i] + 2'd1;
      end else if (ret && (cnt_q[i] != 2'd0)) begin
        cnt_d[i] = cnt_q[i] - 2'd1;
      end
    end
  end

  always_comb begin
    rs1_data = gpr_q[rs1_addr];
    if (gpr_wr && (wb.gpr_waddr == rs1_addr)) begin
      rs1_data = wb.gpr_wdata;
    end
    if (rs1_addr == 4'd0) begin
      rs1_data = '0;
    end
    rs2_data = gpr_q[rs2_addr];
    if (gpr_wr && (wb.gpr_waddr == rs2_addr)) begin
      rs2_data = wb.gpr_wdata;
    end
    if (rs2_addr == 4'd0) begin
      rs2_data = '0;
    end
  end

  always_comb begin
    case (csr_raddr)
      CSR_MSTATUS: csr_rdata = mstatus_q;
      CSR_MTVEC:   csr_rdata = mtvec_q;
      CSR_MEPC:    csr_rdata = mepc_q;
      CSR_MCAUSE:  csr_rdata = mcause_q;
      default:     csr_rdata = '0;
    endcase
  end

  assign hazard = ((rs1_addr != 4'd0) && (cnt_q[rs1_addr] != 2'd0)) ||
                  ((rs2_addr != 4'd0) && (cnt_q[rs2_addr] != 2'd0));
  assign issue_full = (issue_rd != 4'd0) && (cnt_q[issue_rd] == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      wb_ready_q <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        gpr_q[i] <= '0;
        cnt_q[i] <= 2'd0;
      end
      mstatus_q <= MSTATUS_RST;
      mtvec_q   <= '0;
      mepc_q    <= '0;
      mcause_q  <= '0;
    end else begin
      wb_ready_q <= wb_ready_d;
      gpr_q      <= gpr_d;
      cnt_q      <= cnt_d;
      mstatus_q  <= mstatus_d;
      mtvec_q    <= mtvec_d;
      mepc_q     <= mepc_d;
      mcause_q   <= mcause_d;
    end
  end

endmodule

// File: tb/tb_gpr_csr_regfile.sv
// tb/tb_gpr_csr_regfile.sv - directed plus random checks of gpr_csr_regfile against a reference model
module tb_gpr_csr_regfile;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  rs1_addr, rs2_addr;
  logic [31:0] rs1_data, rs2_data;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic [31:0] mtvec_o, mepc_o;
  logic        issue_valid;
  logic [3:0]  issue_rd;
  logic        hazard, issue_full;

  gpr_csr_regfile_if wb_if();

  gpr_csr_regfile dut (
    .clk         (clk),
    .reset       (reset),
    .wb          (wb_if),
    .rs1_addr    (rs1_addr),
    .rs2_addr    (rs2_addr),
    .rs1_data    (rs1_data),
    .rs2_data    (rs2_data),
    .csr_raddr   (csr_raddr),
    .csr_rdata   (csr_rdata),
    .mtvec_o     (mtvec_o),
    .mepc_o      (mepc_o),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .hazard      (hazard),
    .issue_full  (issue_full)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // reference state
  logic [31:0] m_gpr [16];
  int          m_cnt [16];
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  logic        m_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    if (obs !== expv) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, obs, expv);
    end
  endtask

  function automatic logic m_fire();
    return wb_if.wb_valid && m_ready;
  endfunction

  function automatic logic [31:0] exp_rs(input logic [3:0] a);
    if (a == 4'd0) return 32'h0;
    if (m_fire() && wb_if.gpr_we && wb_if.gpr_waddr == a) return wb_if.gpr_wdata;
    return m_gpr[a];
  endfunction

  function automatic logic [31:0] exp_csr(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_hazard();
    return (rs1_addr != 0 && m_cnt[rs1_addr] > 0) || (rs2_addr != 0 && m_cnt[rs2_addr] > 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_gpr[i] = 32'h0;
      m_cnt[i] = 0;
    end
    m_mstatus = 32'h0000_1800;
    m_mtvec   = 32'h0;
    m_mepc    = 32'h0;
    m_mcause  = 32'h0;
    m_ready   = 1'b0;
  endtask

  task automatic model_clock();
    logic iss, ret;
    int   rd, wa;
    if (reset) begin
      model_reset();
      return;
    end
    rd  = int'(issue_rd);
    wa  = int'(wb_if.gpr_waddr);
    iss = issue_valid && rd != 0;
    ret = m_fire() && wb_if.gpr_we && wa != 0;
    if (!(iss && ret && rd == wa)) begin
      if (iss && m_cnt[rd] < 3) m_cnt[rd] = m_cnt[rd] + 1;
      if (ret && m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
    end
    if (ret) m_gpr[wa] = wb_if.gpr_wdata;
    if (m_fire() && wb_if.irq) begin
      m_mepc    = wb_if.csr_wdata;
      m_mcause  = 32'(wb_if.irq_no);
      m_mstatus = (m_mstatus & ~32'h0000_1888) | 32'h0000_1800 |
                  ((m_mstatus & 32'h8) != 0 ? 32'h80 : 32'h0);
    end else if (m_fire() && wb_if.csr_we) begin
      case (wb_if.csr_waddr)
        12'h300: m_mstatus = wb_if.csr_wdata;
        12'h305: m_mtvec   = wb_if.csr_wdata;
        12'h341: m_mepc    = wb_if.csr_wdata;
        12'h342: m_mcause  = wb_if.csr_wdata;
        default: ;
      endcase
    end
    m_ready = 1'b1;
  endtask

  task automatic idle();
    wb_if.wb_valid  = 1'b0;
    wb_if.gpr_we    = 1'b0;
    wb_if.gpr_waddr = 4'd0;
    wb_if.gpr_wdata = 32'h0;
    wb_if.csr_we    = 1'b0;
    wb_if.csr_waddr = 12'h0;
    wb_if.csr_wdata = 32'h0;
    wb_if.irq       = 1'b0;
    wb_if.irq_no    = 8'h0;
    rs1_addr        = 4'd0;
    rs2_addr        = 4'd0;
    csr_raddr       = 12'h0;
    issue_valid     = 1'b0;
    issue_rd        = 4'd0;
  endtask

  task automatic settle();
    #3;
    chk("wb_ready", 32'(wb_if.wb_ready), 32'(m_ready));
    chk("rs1_data", rs1_data, exp_rs(rs1_addr));
    chk("rs2_data", rs2_data, exp_rs(rs2_addr));
    chk("csr_rdata", csr_rdata, exp_csr(csr_raddr));
    chk("mtvec_o", mtvec_o, m_mtvec);
    chk("mepc_o", mepc_o, m_mepc);
    chk("hazard", 32'(hazard), 32'(exp_hazard()));
    chk("issue_full", 32'(issue_full), 32'(issue_rd != 0 && m_cnt[issue_rd] == 3));
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    #1;
  endtask

  task automatic step();
    settle();
    tick();
  endtask

  task automatic gpr_beat(input logic [3:0] a, input logic [31:0] d);
    wb_if.wb_valid  = 1'b1;
    wb_if.gpr_we    = 1'b1;
    wb_if.gpr_waddr = a;
    wb_if.gpr_wdata = d;
  endtask

  task automatic csr_beat(input logic [11:0] a, input logic [31:0] d);
    wb_if.wb_valid  = 1'b1;
    wb_if.csr_we    = 1'b1;
    wb_if.csr_waddr = a;
    wb_if.csr_wdata = d;
  endtask

  function automatic logic [11:0] pick_csr();
    case ($urandom_range(0, 5))
      0: return 12'h300;
      1: return 12'h305;
      2: return 12'h341;
      3: return 12'h342;
      4: return 12'h7C0;
      default: return 12'($urandom);
    endcase
  endfunction

  initial begin
    model_reset();
    idle();
    reset = 1'b1;
    @(posedge clk);
    #1;

    // reset and first write with bypass
    settle(); chk("rst_ready", 32'(wb_if.wb_ready), 32'h0); tick();
    step();
    reset = 1'b0;
    settle(); chk("ready_first", 32'(wb_if.wb_ready), 32'h0); tick();
    gpr_beat(4'd5, 32'hDEAD_BEEF); rs1_addr = 4'd5;
    settle(); chk("ready_up", 32'(wb_if.wb_ready), 32'h1);
    chk("x5_bypass", rs1_data, 32'hDEAD_BEEF); tick();
    idle(); rs1_addr = 4'd5;
    settle(); chk("x5_array", rs1_data, 32'hDEAD_BEEF); tick();

    // x0 and rd=0 issue
    idle(); gpr_beat(4'd0, 32'h1234); rs2_addr = 4'd0; issue_valid = 1'b1; issue_rd = 4'd0;
    settle(); chk("x0_read", rs2_data, 32'h0); tick();
    for (int a = 0; a < 16; a++) begin
      idle(); rs1_addr = 4'(a); issue_rd = 4'(a);
      settle(); chk("no_hazard", 32'(hazard), 32'h0); tick();
    end

    // CSR write, unmapped CSR
    idle(); csr_beat(12'h305, 32'h8000_0100); step();
    idle(); settle(); chk("mtvec_wr", mtvec_o, 32'h8000_0100); tick();
    idle(); csr_beat(12'h7C0, 32'h5); step();
    idle(); csr_raddr = 12'h7C0; settle(); chk("csr_unmapped", csr_rdata, 32'h0); tick();

    // trap entry
    idle(); csr_beat(12'h300, 32'h8); step();
    idle(); csr_beat(12'h305, 32'h8000_0040); wb_if.irq = 1'b1; wb_if.irq_no = 8'd11; step();
    idle(); csr_raddr = 12'h341; settle();
    chk("trap_mepc", csr_rdata, 32'h8000_0040); chk("trap_mepc_o", mepc_o, 32'h8000_0040); tick();
    idle(); csr_raddr = 12'h342; settle(); chk("trap_mcause", csr_rdata, 32'hB); tick();
    idle(); csr_raddr = 12'h300; settle(); chk("trap_mstatus", csr_rdata, 32'h1880);
    chk("trap_mtvec", mtvec_o, 32'h8000_0100); tick();

    // scoreboard saturation
    for (int k = 0; k < 3; k++) begin
      idle(); issue_valid = 1'b1; issue_rd = 4'd7; step();
    end
    idle(); issue_rd = 4'd7; rs1_addr = 4'd7; settle();
    chk("sb_full", 32'(issue_full), 32'h1); chk("sb_hazard", 32'(hazard), 32'h1); tick();
    idle(); gpr_beat(4'd7, 32'h77); issue_valid = 1'b1; issue_rd = 4'd7; step();
    idle(); issue_rd = 4'd7; settle(); chk("sb_same_cycle", 32'(issue_full), 32'h1); tick();
    for (int k = 0; k < 3; k++) begin
      idle(); gpr_beat(4'd7, 32'h70 + 32'(k)); step();
    end
    idle(); issue_rd = 4'd7; rs1_addr = 4'd7; settle();
    chk("sb_drained", 32'(hazard), 32'h0); chk("sb_not_full", 32'(issue_full), 32'h0); tick();

    // reset mid-stream
    idle(); gpr_beat(4'd3, 32'h3333_3333); step();
    for (int k = 0; k < 2; k++) begin
      idle(); issue_valid = 1'b1; issue_rd = 4'd3; step();
    end
    idle(); reset = 1'b1; step();
    reset = 1'b0; step();
    idle(); rs1_addr = 4'd3; issue_rd = 4'd3; settle();
    chk("rst_hazard", 32'(hazard), 32'h0); chk("rst_x3", rs1_data, 32'h0);
    chk("rst_full", 32'(issue_full), 32'h0); tick();
    idle(); gpr_beat(4'd3, 32'h1); step();
    idle(); rs1_addr = 4'd3; settle(); chk("underflow", 32'(hazard), 32'h0); tick();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      reset           = ($urandom_range(0, 99) == 0);
      wb_if.wb_valid  = 1'($urandom);
      wb_if.gpr_we    = 1'($urandom);
      wb_if.gpr_waddr = 4'($urandom);
      wb_if.gpr_wdata = $urandom;
      wb_if.csr_we    = ($urandom_range(0, 2) == 0);
      wb_if.csr_waddr = pick_csr();
      wb_if.csr_wdata = $urandom;
      wb_if.irq       = ($urandom_range(0, 9) == 0);
      wb_if.irq_no    = 8'($urandom);
      rs1_addr        = 4'($urandom);
      rs2_addr        = 4'($urandom);
      csr_raddr       = pick_csr();
      issue_valid     = 1'($urandom);
      issue_rd        = 4'($urandom_range(0, 7));
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
